line_clear: RTL and testbench

- Consumer-side counterpart to the full-row score counter. It takes a 200-bit playfield snapshot, removes every full row and compacts the rows above it downward.
- Returns the compacted map and the number of rows removed, using a start/busy/done handshake.
- Sits between the game-logic FSM, which writes the locked map, and the map register / score accumulator.

---
 rtl/line_clear_pkg.sv | 15 +
 rtl/line_clear_row_select.sv | 25 ++
 rtl/line_clear.sv | 141 ++++++++++++++
 tb/tb_line_clear.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/line_clear_pkg.sv
// Shared playfield constants and FSM encoding for the line-clear block.
package line_clear_pkg;

    localparam int MAP_ROWS = 20;
    localparam int MAP_COLS = 10;
    localparam int MAP_BITS = MAP_ROWS * MAP_COLS;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        LC_IDLE = 2'd0,
        LC_SCAN = 2'd1,
        LC_DONE = 2'd2
    } lc_state_e;

endpackage

// File: rtl/line_clear_row_select.sv
// Combinational row extractor: gathers the COLS cells of row row_idx from a
// column-major playfield (cell (r,c) = bit r + ROWS*c) and flags a full row.
module row_select
    import line_clear_pkg::*;
#(
    parameter int ROWS = MAP_ROWS,
    parameter int COLS = MAP_COLS,
    parameter int PW   = $clog2(ROWS)
) (
    input  logic [ROWS*COLS-1:0] map_in,
    input  logic [PW-1:0]        row_idx,
    output logic [COLS-1:0]      row_bits,
    output logic                 row_full
);

    localparam int IW = $clog2(ROWS*COLS);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam logic [IW-1:0] BASE = IW'(ROWS * c);
        assign row_bits[c] = map_in[BASE + IW'(row_idx)];
    end

    assign row_full = &row_bits;

endmodule

// File: rtl/line_clear.sv
// Removes every full row of a playfield snapshot, one row examined per cycle,
// compacting the rows above each removed row downward.
module line_clear
    import line_clear_pkg::*;
#(
    parameter int ROWS = MAP_ROWS,
    parameter int COLS = MAP_COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] map_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] map_out,
    output logic [CNT_W-1:0]     lines_cleared
);

    localparam int PW = $clog2(ROWS);

    lc_state_e               state_r;
    lc_state_e               next_state_s;
    logic [ROWS*COLS-1:0]    work_r;
    logic [ROWS*COLS-1:0]    shift_map_s;
    logic [PW-1:0]           ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    busy_r;
    logic                    done_r;
    logic [ROWS*COLS-1:0]    map_out_r;
    logic [CNT_W-1:0]        lines_r;
    logic [COLS-1:0]         row_bits_s;
    logic                    row_full_s;

    row_select #(
        .ROWS (ROWS),
        .COLS (COLS),
        .PW   (PW)
    ) u_row_select (
        .map_in   (work_r),
        .row_idx  (ptr_r),
        .row_bits (row_bits_s),
        .row_full (row_full_s)
    );

    // Working map with the row at ptr_r removed: rows at or above the pointer
    // drop by one, row 0 fills with zeros, rows below the pointer are kept.
    for (genvar k = 0; k < ROWS; k++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_cell
            if (k == 0) begin : g_top
                assign shift_map_s[k + ROWS*c] =
                    (PW'(k) > ptr_r) ? work_r[k + ROWS*c] : 1'b0;
            end else begin : g_rest
                assign shift_map_s[k + ROWS*c] =
                    (PW'(k) > ptr_r) ? work_r[k + ROWS*c] : work_r[k - 1 + ROWS*c];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LC_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: scan ends once row 0 is examined and found not full.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LC_IDLE: begin
                if (start) begin
                    next_state_s = LC_SCAN;
                end else begin
                    next_state_s = LC_IDLE;
                end
            end
            LC_SCAN: begin
                if (!row_full_s && (ptr_r == {PW{1'b0}})) begin
                    next_state_s = LC_DONE;
                end else begin
                    next_state_s = LC_SCAN;
                end
            end
            LC_DONE: next_state_s = LC_IDLE;
            default: next_state_s = LC_IDLE;
        endcase
    end

    // Datapath: capture on accept, shift/step during scan, publish results as
    // the FSM enters DONE so done and the results appear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_r    <= '0;
            ptr_r     <= PW'(ROWS - 1);
            count_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            map_out_r <= '0;
            lines_r   <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                LC_IDLE: begin
                    if (start) begin
                        work_r  <= map_in;
                        ptr_r   <= PW'(ROWS - 1);
                        count_r <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                LC_SCAN: begin
                    if (row_full_s) begin
                        work_r  <= shift_map_s;
                        count_r <= count_r + 5'd1;
                    end else if (ptr_r != {PW{1'b0}}) begin
                        ptr_r <= ptr_r - PW'(1);
                    end else begin
                        map_out_r <= work_r;
                        lines_r   <= count_r;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                LC_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign map_out       = map_out_r;
    assign lines_cleared = lines_r;

endmodule

// File: tb/tb_line_clear.sv
// Randomized and directed bench for line_clear against a row-list reference model.
module tb_line_clear;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int NB   = ROWS * COLS;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NB-1:0] map_in;
    logic          busy;
    logic          done;
    logic [NB-1:0] map_out;
    logic [4:0]    lines_cleared;

    int errors;
    int checks;

    line_clear dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .map_in        (map_in),
        .busy          (busy),
        .done          (done),
        .map_out       (map_out),
        .lines_cleared (lines_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] set_cell(input logic [NB-1:0] m, input int r, input int c);
        logic [NB-1:0] t;
        t = m;
        t[r + ROWS*c] = 1'b1;
        return t;
    endfunction

    function automatic logic [NB-1:0] fill_row(input logic [NB-1:0] m, input int r);
        logic [NB-1:0] t;
        t = m;
        for (int c = 0; c < COLS; c++) t[r + ROWS*c] = 1'b1;
        return t;
    endfunction

    // Reference: keep the non-full rows in order, stacked from the bottom.
    function automatic logic [NB-1:0] model_map(input logic [NB-1:0] m);
        logic [NB-1:0] res;
        logic [COLS-1:0] rowv;
        int dst;
        res = '0;
        dst = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = 0; c < COLS; c++) rowv[c] = m[r + ROWS*c];
            if (rowv != {COLS{1'b1}}) begin
                for (int c = 0; c < COLS; c++) res[dst + ROWS*c] = rowv[c];
                dst--;
            end
        end
        return res;
    endfunction

    function automatic int model_cnt(input logic [NB-1:0] m);
        int n;
        logic [COLS-1:0] rowv;
        n = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) rowv[c] = m[r + ROWS*c];
            if (rowv == {COLS{1'b1}}) n++;
        end
        return n;
    endfunction

    // Called #1 after a clock edge. mode 1: extra start mid-scan; mode 2: start during done.
    task automatic run_op(input string tag, input logic [NB-1:0] m, input int mode);
        logic [NB-1:0] exp_map;
        int exp_cnt;
        int n;
        bit seen;
        exp_map = model_map(m);
        exp_cnt = model_cnt(m);
        map_in = m;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        map_in = ~m;
        check_eq({tag, "_busy"}, 256'(busy), 256'd1);
        n = 1;
        seen = done;
        while (!seen && n < 2*ROWS + 10) begin
            if (mode == 1 && n == 5) start = 1'b1;
            if (mode == 1 && n == 6) start = 1'b0;
            @(posedge clk); #1;
            n++;
            seen = done;
        end
        check_eq({tag, "_done_seen"}, 256'(seen), 256'd1);
        check_eq({tag, "_latency"}, 256'(n), 256'(ROWS + 1 + exp_cnt));
        check_eq({tag, "_busy_at_done"}, 256'(busy), 256'd0);
        check_eq({tag, "_lines"}, 256'(lines_cleared), 256'(exp_cnt));
        check_eq({tag, "_map"}, 256'(map_out), 256'(exp_map));
        if (mode == 2) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_done_pulse"}, 256'(done), 256'd0);
        check_eq({tag, "_idle_busy"}, 256'(busy), 256'd0);
        check_eq({tag, "_hold_map"}, 256'(map_out), 256'(exp_map));
    endtask

    initial begin
        logic [NB-1:0] m;
        bit saw_done;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        start = 1'b0;
        map_in = '0;
        @(posedge clk); #1;
        check_eq("rst_busy", 256'(busy), 256'd0);
        check_eq("rst_done", 256'(done), 256'd0);
        check_eq("rst_map", 256'(map_out), 256'd0);
        check_eq("rst_lines", 256'(lines_cleared), 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("empty", '0, 0);

        m = fill_row('0, 19);
        m = set_cell(m, 18, 0);
        run_op("bottom", m, 0);
        check_eq("bottom_bit19", 256'(map_out), 256'd1 << 19);

        m = '0;
        for (int r = 16; r < 20; r++) m = fill_row(m, r);
        m = set_cell(m, 15, 3);
        run_op("tetris", m, 0);
        check_eq("tetris_bit79", 256'(map_out), 256'd1 << 79);

        m = fill_row('0, 19);
        m = fill_row(m, 17);
        for (int c = 0; c < 9; c++) m = set_cell(m, 18, c);
        m = set_cell(m, 16, 9);
        run_op("gap", m, 0);
        check_eq("gap_lines2", 256'(lines_cleared), 256'd2);

        m = '1;
        run_op("full", m, 1);
        check_eq("full_zero", 256'(map_out), 256'd0);

        m = fill_row('0, 10);
        m = set_cell(m, 3, 4);
        run_op("done_start", m, 2);
        run_op("b2b_a", fill_row('0, 0), 0);
        run_op("b2b_b", fill_row(set_cell('0, 19, 2), 5), 0);

        for (int i = 0; i < 12; i++) begin
            m = '0;
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 2) == 0) begin
                    m = fill_row(m, r);
                end else begin
                    for (int c = 0; c < COLS; c++) m[r + ROWS*c] = 1'($urandom_range(0, 1));
                end
            end
            run_op($sformatf("rand%0d", i), m, 0);
        end

        // Reset mid-scan abandons the operation.
        map_in = fill_row('0, 19);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_eq("mid_rst_map", 256'(map_out), 256'd0);
        check_eq("mid_rst_lines", 256'(lines_cleared), 256'd0);
        check_eq("mid_rst_busy", 256'(busy), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check_eq("mid_rst_no_done", 256'(saw_done), 256'd0);

        run_op("after_rst", fill_row(fill_row('0, 19), 18), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
